// File: rtl/ram_bist_ctrl.sv
// Write/read-back BIST initiator for a single-port EN/WR synchronous RAM.
// Optional macro RAM_BIST_STOP_ON_FAIL_EN: the first mismatch ends the read sweep early.
module ram_bist_ctrl #(
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int MASK   = 7,
  parameter int SEED   = 3,
  parameter int RD_LAT = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          EN,
  output logic          WR,
  input  logic [DW-1:0] Q,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [7:0]    ERR_CNT,
  output logic [AW-1:0] FAIL_ADDR
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam int          LAST       = RD_LAT - 1;
  localparam logic [DW-1:0] MSK      = DW'(MASK);
  localparam logic [7:0]  DRAIN_LAST = 8'(RD_LAT);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [7:0]    dcnt;
  logic          rv [RD_LAT];
  logic [AW-1:0] ra [RD_LAT];
  logic [DW-1:0] exp_q;
  logic          mism;
  logic          stop;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return DW'(SEED) + DW'(a);
  endfunction

  always_comb begin
    exp_q = pat(ra[LAST]) & MSK;
    mism  = rv[LAST] && (Q != exp_q);
  end

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  assign stop = mism;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      A         <= '0;
      D         <= '0;
      EN        <= 1'b0;
      WR        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_ADDR <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        rv[i] <= 1'b0;
        ra[i] <= '0;
      end
    end else begin
      // Stage 0 is loaded alongside A/EN so it tracks the issued read exactly.
      rv[0] <= 1'b0;
      ra[0] <= cnt;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rv[i] <= rv[i-1];
        ra[i] <= ra[i-1];
      end

      if (mism) begin
        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 8'd1;
        if (ERR_CNT == '0) FAIL_ADDR <= ra[LAST];
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state     <= S_WRITE;
            cnt       <= '0;
            ERR_CNT   <= '0;
            FAIL_ADDR <= '0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            BUSY      <= 1'b1;
          end
        end
        S_WRITE: begin
          A   <= cnt;
          D   <= pat(cnt);
          EN  <= 1'b1;
          WR  <= 1'b1;
          cnt <= cnt + AW'(1);
          if (cnt == '1) state <= S_READ;
        end
        S_READ: begin
          if (stop) begin
            EN    <= 1'b0;
            WR    <= 1'b0;
            D     <= '0;
            dcnt  <= '0;
            state <= S_DRAIN;
          end else begin
            A     <= cnt;
            D     <= '0;
            EN    <= 1'b1;
            WR    <= 1'b0;
            rv[0] <= 1'b1;
            cnt   <= cnt + AW'(1);
            if (cnt == '1) begin
              dcnt  <= '0;
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          EN <= 1'b0;
          WR <= 1'b0;
          // One extra edge past RD_LAT so the final compare lands in ERR_CNT first.
          if (dcnt == DRAIN_LAST) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (ERR_CNT == '0);
          end else begin
            dcnt <= dcnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: 16-word RAM model with per-address faults,
// plus a 512-word always-corrupt instance for ERR_CNT saturation.
module tb_ram_bist_ctrl;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic       START0, EN0, WR0, BUSY0, DONE0, PASS0;
  logic [3:0] A0, D0, Q0, FAIL0;
  logic [7:0] ERR0;
  logic [15:0] fault0;
  logic [3:0] mem0 [16];

  logic       START1, EN1, WR1, BUSY1, DONE1, PASS1;
  logic [8:0] A1, FAIL1;
  logic [3:0] D1, Q1;
  logic [7:0] ERR1;
  logic [3:0] mem1 [512];

  int checks = 0;
  int errors = 0;

  ram_bist_ctrl #(.AW(4), .DW(4), .MASK(7), .SEED(3), .RD_LAT(2)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .START(START0), .A(A0), .D(D0), .EN(EN0), .WR(WR0),
    .Q(Q0), .BUSY(BUSY0), .DONE(DONE0), .PASS(PASS0), .ERR_CNT(ERR0), .FAIL_ADDR(FAIL0));

  ram_bist_ctrl #(.AW(9), .DW(4), .MASK(7), .SEED(3), .RD_LAT(2)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(START1), .A(A1), .D(D1), .EN(EN1), .WR(WR1),
    .Q(Q1), .BUSY(BUSY1), .DONE(DONE1), .PASS(PASS1), .ERR_CNT(ERR1), .FAIL_ADDR(FAIL1));

  always @(posedge CLK) begin
    if (EN0 && WR0) mem0[A0] <= D0 & 4'h7;
    if (EN0 && !WR0) Q0 <= (mem0[A0] & 4'h7) ^ {3'b000, fault0[A0]};
  end

  always @(posedge CLK) begin
    if (EN1 && WR1) mem1[A1] <= D1 & 4'h7;
    if (EN1 && !WR1) Q1 <= (mem1[A1] & 4'h7) ^ 4'h1;
  end

  task automatic kick0();
    @(negedge CLK); START0 = 1'b1;
    @(posedge CLK); #1; START0 = 1'b0;
  endtask

  // Returns the edge index (relative to the START edge) where DONE0 is first seen; -1 on timeout.
  task automatic wait_done0(input int start_at, output int edge_no);
    int e = start_at;
    edge_no = -1;
    while (e < start_at + 200) begin
      @(posedge CLK); #1; e++;
      if (DONE0) begin edge_no = e; break; end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START0 = 1'b0; START1 = 1'b0; fault0 = '0; Q0 = '0; Q1 = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({A0, D0, EN0, WR0, BUSY0, DONE0, PASS0, ERR0, FAIL0} !== '0) begin
      errors++;
      $display("FAIL reset_state: got A=%0h D=%0h EN=%b WR=%b BUSY=%b DONE=%b PASS=%b ERR=%0d FA=%0h expected all 0",
               A0, D0, EN0, WR0, BUSY0, DONE0, PASS0, ERR0, FAIL0);
    end
    @(negedge CLK); RST_N = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] ea, ed;
    logic       een, ewr;
    int         done_at = -1;
    kick0();
    checks++;
    if (BUSY0 !== 1'b1 || EN0 !== 1'b0) begin
      errors++; $display("FAIL start_edge: BUSY=%b EN=%b expected BUSY=1 EN=0", BUSY0, EN0);
    end
    for (int e = 1; e <= 60; e++) begin
      @(posedge CLK); #1;
      if (e <= 34) begin
        ea = 4'h0; ed = 4'h0; een = 1'b0; ewr = 1'b0;
        if (e <= 16) begin
          ea = 4'(e - 1); ed = 4'(e + 2); een = 1'b1; ewr = 1'b1;
        end else if (e <= 32) begin
          ea = 4'(e - 17); een = 1'b1;
        end
        checks++;
        if (e <= 32 ? ({A0, D0, EN0, WR0} !== {ea, ed, een, ewr}) : ({EN0, WR0} !== 2'b00)) begin
          errors++;
          $display("FAIL bus_edge%0d: got A=%0h D=%0h EN=%b WR=%b expected A=%0h D=%0h EN=%b WR=%b",
                   e, A0, D0, EN0, WR0, ea, ed, een, ewr);
        end
      end
      if (DONE0) begin done_at = e; break; end
    end
    checks++;
    if (done_at != 35) begin errors++; $display("FAIL basic_done_edge: got %0d expected 35", done_at); end
    checks++;
    if ({PASS0, BUSY0, ERR0, FAIL0} !== {1'b1, 1'b0, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL basic_result: got PASS=%b BUSY=%b ERR=%0d FA=%0d expected PASS=1 BUSY=0 ERR=0 FA=0",
               PASS0, BUSY0, ERR0, FAIL0);
    end
  endtask

  task automatic test_faults();
    int         done_at;
    int         exp_done;
    logic [7:0] exp_err;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    exp_done = 27; exp_err = 8'd1;
`else
    exp_done = 35; exp_err = 8'd2;
`endif
    fault0 = 16'h0220;
    kick0();
    wait_done0(0, done_at);
    checks++;
    if (done_at != exp_done) begin
      errors++; $display("FAIL fault_done_edge: got %0d expected %0d", done_at, exp_done);
    end
    checks++;
    if ({PASS0, ERR0, FAIL0} !== {1'b0, exp_err, 4'd5}) begin
      errors++;
      $display("FAIL fault_result: got PASS=%b ERR=%0d FA=%0d expected PASS=0 ERR=%0d FA=5",
               PASS0, ERR0, FAIL0, exp_err);
    end
    fault0 = '0;
  endtask

  task automatic test_restart_ignored();
    int done_at;
    kick0();
    checks++;
    if (DONE0 !== 1'b0 || PASS0 !== 1'b0) begin
      errors++; $display("FAIL restart_clear: DONE=%b PASS=%b expected 0 0", DONE0, PASS0);
    end
    repeat (6) @(posedge CLK);
    @(negedge CLK); START0 = 1'b1;
    @(posedge CLK); #1; START0 = 1'b0;
    checks++;
    if ({A0, EN0, WR0} !== {4'd6, 1'b1, 1'b1}) begin
      errors++; $display("FAIL restart_at_write6: got A=%0d EN=%b WR=%b expected A=6 EN=1 WR=1", A0, EN0, WR0);
    end
    wait_done0(7, done_at);
    checks++;
    if (done_at != 35 || PASS0 !== 1'b1 || ERR0 !== 8'd0) begin
      errors++;
      $display("FAIL restart_ignored: got done=%0d PASS=%b ERR=%0d expected done=35 PASS=1 ERR=0",
               done_at, PASS0, ERR0);
    end
  endtask

  task automatic test_reset_mid();
    int done_at;
    kick0();
    repeat (7) @(posedge CLK);
    #1; RST_N = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({EN0, BUSY0, DONE0, PASS0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_abort: got EN=%b BUSY=%b DONE=%b PASS=%b expected 0000", EN0, BUSY0, DONE0, PASS0);
    end
    @(negedge CLK); RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({EN0, BUSY0, DONE0} !== 3'b000) begin
      errors++; $display("FAIL reset_stays_idle: got EN=%b BUSY=%b DONE=%b expected 000", EN0, BUSY0, DONE0);
    end
    kick0();
    wait_done0(0, done_at);
    checks++;
    if (done_at != 35 || {PASS0, ERR0, FAIL0} !== {1'b1, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL rerun_after_reset: got done=%0d PASS=%b ERR=%0d FA=%0d expected 35 1 0 0",
               done_at, PASS0, ERR0, FAIL0);
    end
  endtask

  task automatic test_saturate();
    int         done_at = -1;
    int         exp_done;
    logic [7:0] exp_err;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    exp_done = 518; exp_err = 8'd2;
`else
    exp_done = 1027; exp_err = 8'd255;
`endif
    @(negedge CLK); START1 = 1'b1;
    @(posedge CLK); #1; START1 = 1'b0;
    for (int e = 1; e <= 1200; e++) begin
      @(posedge CLK); #1;
      if (DONE1) begin done_at = e; break; end
    end
    checks++;
    if (done_at != exp_done) begin
      errors++; $display("FAIL sat_done_edge: got %0d expected %0d", done_at, exp_done);
    end
    checks++;
    if ({PASS1, ERR1, FAIL1} !== {1'b0, exp_err, 9'd0}) begin
      errors++;
      $display("FAIL sat_result: got PASS=%b ERR=%0d FA=%0d expected PASS=0 ERR=%0d FA=0",
               PASS1, ERR1, FAIL1, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_faults();
    test_restart_ignored();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
